roll_mem_writer: RTL and testbench

Writer side of the 32-entry, 5-bit dice-entropy memory that the d20 roll datapath reads by program counter. It contains the storage array, fills it from a 16-bit Galois LFSR on request, and replaces single consumed entries on demand. It exposes a combinational read port with the same address/data convention the roll datapath already uses.

---
 rtl/roll_pkg.sv | 27 ++
 rtl/roll_mem_writer_if.sv | 31 +++
 rtl/roll_lfsr.sv | 29 ++
 rtl/roll_mem_writer.sv | 103 ++++++++++
 tb/tb_roll_mem_writer.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/roll_pkg.sv
// Shared types, constants and LFSR helpers for the dice-entropy memory writer.
package roll_pkg;

  localparam int ROLL_W        = 5;
  localparam int LFSR_W        = 16;
  localparam int NUM_GROUP_DEF = 32;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  typedef logic [ROLL_W-1:0] roll_t;

  // An all-zero LFSR would lock up, so zero seeds are promoted to 1.
  function automatic logic [LFSR_W-1:0] lfsr_nz(input logic [LFSR_W-1:0] v);
    return (v == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : v;
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    logic [LFSR_W-1:0] shifted;
    shifted = v >> 1;
    return v[0] ? (shifted ^ LFSR_TAPS) : shifted;
  endfunction

endpackage

// File: rtl/roll_mem_writer_if.sv
// Request/status and read-port bundle of the entropy memory writer.
interface roll_mem_writer_if;
  import roll_pkg::*;

  // start/seed_load/refill_req are single-cycle requests, honoured only when
  // dbg_state is IDLE; an accepted refill_req answers with a refill_ack pulse
  // on the following cycle and there is no backpressure on the requester.
  logic                start;
  logic                seed_load;
  logic [LFSR_W-1:0]   seed_i;
  logic                refill_req;
  logic [ROLL_W-1:0]   refill_addr;
  logic                refill_ack;
  logic [31:0]         rd_addr_i;
  roll_t               rd_data_o;
  logic                busy;
  logic                done;
  logic [5:0]          fill_count;
  state_t              dbg_state;

  modport master (
    output start, seed_load, seed_i, refill_req, refill_addr, rd_addr_i,
    input  refill_ack, rd_data_o, busy, done, fill_count, dbg_state
  );

  modport slave (
    input  start, seed_load, seed_i, refill_req, refill_addr, rd_addr_i,
    output refill_ack, rd_data_o, busy, done, fill_count, dbg_state
  );

endinterface

// File: rtl/roll_lfsr.sv
// 16-bit Galois right-shift LFSR with load; never holds zero.
module roll_lfsr
  import roll_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_step,
  input  logic              i_load,
  input  logic [LFSR_W-1:0] i_load_val,
  output logic [LFSR_W-1:0] o_lfsr
);

  logic [LFSR_W-1:0] r_lfsr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr <= lfsr_nz(SEED);
    end else if (i_load) begin
      r_lfsr <= lfsr_nz(i_load_val);
    end else if (i_step) begin
      r_lfsr <= lfsr_step(r_lfsr);
    end
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/roll_mem_writer.sv
// Entropy RAM writer: full LFSR fill on start, single-entry refill on demand,
// combinational read port addressed modulo NUM_GROUP.
module roll_mem_writer
  import roll_pkg::*;
#(
  parameter int                NUM_GROUP = NUM_GROUP_DEF,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset_n,
  roll_mem_writer_if.slave  bus
);

  localparam int AW = $clog2(NUM_GROUP);
  localparam logic [AW-1:0] LAST_PTR = AW'(NUM_GROUP - 1);

  state_t        r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [5:0]    r_fill_count;
  logic          r_done;
  logic          r_refill_ack;
  roll_t         r_ram [NUM_GROUP];

  logic [LFSR_W-1:0] w_lfsr;
  logic              w_idle;
  logic              w_take_refill;
  logic              w_take_seed;
  logic              w_wr_en;
  logic [AW-1:0]     w_wr_addr;
  logic [AW-1:0]     w_refill_idx;
  logic [AW-1:0]     w_rd_idx;

  // Request priority in IDLE: start wins, then refill, then seed load.
  assign w_idle        = (r_state == IDLE);
  assign w_take_refill = w_idle && !bus.start && bus.refill_req;
  assign w_take_seed   = w_idle && !bus.start && !bus.refill_req && bus.seed_load;

  // NUM_GROUP is a power of two, so modulo is just the low address bits.
  assign w_refill_idx = AW'(bus.refill_addr);
  assign w_rd_idx     = AW'(bus.rd_addr_i);

  assign w_wr_en   = (r_state == FILL) || w_take_refill;
  assign w_wr_addr = (r_state == FILL) ? r_wr_ptr : w_refill_idx;

  roll_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_step     (w_wr_en),
    .i_load     (w_take_seed),
    .i_load_val (bus.seed_i),
    .o_lfsr     (w_lfsr)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_wr_ptr     <= '0;
      r_fill_count <= '0;
      r_done       <= 1'b0;
      r_refill_ack <= 1'b0;
      for (int i = 0; i < NUM_GROUP; i++) begin
        r_ram[i] <= '0;
      end
    end else begin
      r_refill_ack <= w_take_refill;

      // Each write stores the pre-step LFSR value; the LFSR steps on the same edge.
      if (w_wr_en) begin
        r_ram[w_wr_addr] <= w_lfsr[ROLL_W-1:0];
      end

      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state      <= FILL;
            r_wr_ptr     <= '0;
            r_fill_count <= '0;
            r_done       <= 1'b0;
          end
        end
        FILL: begin
          r_wr_ptr     <= r_wr_ptr + 1'b1;
          r_fill_count <= r_fill_count + 6'd1;
          if (r_wr_ptr == LAST_PTR) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rd_data_o  = r_ram[w_rd_idx];
  assign bus.busy       = (r_state == FILL);
  assign bus.done       = r_done;
  assign bus.fill_count = r_fill_count;
  assign bus.refill_ack = r_refill_ack;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_roll_mem_writer.sv
// Randomized bench for roll_mem_writer against a transaction-level model.
module tb_roll_mem_writer;
  import roll_pkg::*;

  localparam int N = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  roll_mem_writer_if bus ();

  roll_mem_writer #(
    .NUM_GROUP (N),
    .SEED      (16'hACE1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- reference model ----------------
  logic [4:0]  m_ram [N];
  logic [4:0]  t1_ram [N];
  logic [15:0] m_lfsr;
  logic        m_done;
  int          m_fill;
  logic [4:0]  exp_q [$];

  int n_checks = 0;
  int n_err    = 0;

  function automatic logic [15:0] m_next(input logic [15:0] x);
    if (x % 2 == 1) return (x / 2) ^ 16'hB400;
    return x / 2;
  endfunction

  function automatic logic [15:0] m_fix(input logic [15:0] x);
    return (x == 16'd0) ? 16'd1 : x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_ram[i] = 5'd0;
    m_lfsr = 16'hACE1;
    m_done = 1'b0;
    m_fill = 0;
    exp_q.delete();
  endtask

  task automatic model_write(input int idx);
    m_ram[idx] = m_lfsr[4:0];
    m_lfsr     = m_next(m_lfsr);
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start       = 1'b0;
    bus.seed_load   = 1'b0;
    bus.seed_i      = 16'd0;
    bus.refill_req  = 1'b0;
    bus.refill_addr = 5'd0;
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_busy"},  32'(bus.busy),       32'(1'b0));
    chk({tag, "_done"},  32'(bus.done),       32'(m_done));
    chk({tag, "_count"}, 32'(bus.fill_count), 32'(m_fill));
    chk({tag, "_ack"},   32'(bus.refill_ack), 32'(1'b0));
  endtask

  task automatic check_ram(input string tag);
    for (int i = 0; i < N; i++) begin
      bus.rd_addr_i = 32'(i) + 32'(N) * $urandom_range(0, 1000);
      #1;
      chk(tag, 32'(bus.rd_data_o), 32'(m_ram[i]));
    end
  endtask

  // Called right after the edge that accepted start.
  task automatic run_fill(input bit noise);
    int   cnt;
    logic ack_seen;
    for (int k = 0; k < N; k++) begin
      exp_q.push_back(m_lfsr[4:0]);
      model_write(k);
    end
    chk("fill_done_clr",   32'(bus.done),       32'(1'b0));
    chk("fill_count_zero", 32'(bus.fill_count), 32'd0);
    chk("fill_state",      32'(bus.dbg_state),  32'(FILL));
    cnt = 0;
    ack_seen = 1'b0;
    while (bus.busy && cnt < 200) begin
      cnt++;
      if (bus.refill_ack) ack_seen = 1'b1;
      if (noise) begin
        bus.start       = 1'($urandom_range(0, 1));
        bus.refill_req  = 1'($urandom_range(0, 1));
        bus.seed_load   = 1'($urandom_range(0, 1));
        bus.seed_i      = 16'($urandom);
        bus.refill_addr = 5'($urandom_range(0, 31));
      end
      cyc();
    end
    clear_inputs();
    chk("busy_cycles", 32'(cnt), 32'(N));
    chk("fill_no_ack", 32'(ack_seen), 32'(1'b0));
    m_done = 1'b1;
    m_fill = N;
    check_status("after_fill");
    for (int i = 0; i < N; i++) begin
      bus.rd_addr_i = 32'(i);
      #1;
      chk("fill_data", 32'(bus.rd_data_o), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic do_start(input bit with_refill, input bit noise);
    cyc();
    bus.start       = 1'b1;
    bus.refill_req  = with_refill;
    bus.refill_addr = 5'($urandom_range(0, 31));
    bus.seed_load   = with_refill;
    bus.seed_i      = 16'($urandom);
    cyc();
    clear_inputs();
    m_fill = 0;
    run_fill(noise);
  endtask

  task automatic do_refill(input int addr);
    cyc();
    bus.rd_addr_i   = 32'(addr) + 32'(N) * $urandom_range(0, 1000);
    bus.refill_req  = 1'b1;
    bus.refill_addr = 5'(addr);
    #1;
    chk("rdw_old", 32'(bus.rd_data_o), 32'(m_ram[addr]));
    model_write(addr);
    cyc();
    clear_inputs();
    chk("rdw_new",    32'(bus.rd_data_o),  32'(m_ram[addr]));
    chk("refill_ack", 32'(bus.refill_ack), 32'(1'b1));
    chk("refill_busy", 32'(bus.busy),      32'(1'b0));
    chk("refill_done", 32'(bus.done),      32'(m_done));
    cyc();
    chk("refill_ack_drop", 32'(bus.refill_ack), 32'(1'b0));
  endtask

  task automatic do_seed(input logic [15:0] v);
    cyc();
    bus.seed_load = 1'b1;
    bus.seed_i    = v;
    cyc();
    clear_inputs();
    m_lfsr = m_fix(v);
  endtask

  task automatic idle_mix();
    logic        r;
    logic        sl;
    int          addr;
    logic [15:0] sv;
    r    = 1'($urandom_range(0, 1));
    sl   = 1'($urandom_range(0, 1));
    addr = $urandom_range(0, N - 1);
    sv   = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
    cyc();
    bus.refill_req  = r;
    bus.refill_addr = 5'(addr);
    bus.seed_load   = sl;
    bus.seed_i      = sv;
    cyc();
    clear_inputs();
    if (r) model_write(addr);
    else if (sl) m_lfsr = m_fix(sv);
    chk("mix_ack", 32'(bus.refill_ack), 32'(r));
    chk("mix_busy", 32'(bus.busy), 32'(1'b0));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [4:0] t1_head [4];
    logic [4:0] t2_head [3];
    int         cnt;
    t1_head = '{5'd1, 5'd16, 5'd24, 5'd28};
    t2_head = '{5'd1, 5'd0, 5'd0};
    clear_inputs();
    bus.rd_addr_i = 32'd0;
    model_reset();

    repeat (3) cyc();
    reset_n = 1'b1;
    check_status("reset");
    chk("reset_state", 32'(bus.dbg_state), 32'(IDLE));
    check_ram("reset_ram");

    // Fill from the reset seed and check the known leading values.
    do_start(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bus.rd_addr_i = 32'(i);
      #1;
      chk("t1_head", 32'(bus.rd_data_o), 32'(t1_head[i]));
    end
    for (int i = 0; i < N; i++) t1_ram[i] = m_ram[i];

    bus.rd_addr_i = 32'd37;
    #1;
    chk("rd_mod", 32'(bus.rd_data_o), 32'(m_ram[5]));

    do_refill(5);
    check_ram("after_refill");

    // Zero seed is promoted to 1: values 1, B400, 5A00.
    do_seed(16'd0);
    do_start(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bus.rd_addr_i = 32'(i);
      #1;
      chk("t2_head", 32'(bus.rd_data_o), 32'(t2_head[i]));
    end

    // Simultaneous start+refill+seed_load, then noisy requests during FILL.
    do_start(1'b1, 1'b1);

    for (int round = 0; round < 3; round++) begin
      repeat (15) idle_mix();
      check_ram("mix_ram");
      do_refill($urandom_range(0, N - 1));
      do_seed(16'($urandom));
      do_start(1'($urandom_range(0, 1)), 1'b1);
    end

    // Reset partway through a fill.
    cyc();
    bus.start = 1'b1;
    cyc();
    clear_inputs();
    repeat (10) cyc();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_status("midfill_reset");
    chk("midfill_state", 32'(bus.dbg_state), 32'(IDLE));
    check_ram("midfill_ram");
    cyc();
    reset_n = 1'b1;
    do_start(1'b0, 1'b0);
    for (int i = 0; i < N; i++) begin
      bus.rd_addr_i = 32'(i);
      #1;
      chk("replay_t1", 32'(bus.rd_data_o), 32'(t1_ram[i]));
    end

    // done must stay set across idle cycles without a start.
    repeat (5) cyc();
    cnt = 0;
    chk("done_sticky", 32'(bus.done), 32'(1'b1));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
